// File: rtl/ldst_pkg.sv
// Shared definitions for the load/store execute stage: FSM state encoding,
// lane-select width and byte-lane helper functions used by the datapath.
package ldst_pkg;

  // Execute-stage FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WB    = 2'd2,
    ST_FAULT = 2'd3
  } ldst_state_t;

  // Default data width and the matching byte-lane select width.
  localparam int DW_DEF = 32;
  localparam int LANEW  = $clog2(DW_DEF / 8);

  // Helpers are written for the widest supported bus; callers size the
  // arguments up and the results down with casts.
  localparam int MAXDW    = 128;
  localparam int MAXLANES = MAXDW / 8;
  localparam int MAXLANEW = $clog2(MAXLANES);

  // Byte value copied onto every lane of the bus.
  function automatic logic [MAXDW-1:0] byte_replicate(input logic [7:0] b);
    return {MAXLANES{b}};
  endfunction

  // One-hot byte enable for the addressed lane.
  function automatic logic [MAXLANES-1:0] be_decode(input logic [MAXLANEW-1:0] lane);
    logic [MAXLANES-1:0] be;
    be       = '0;
    be[lane] = 1'b1;
    return be;
  endfunction

  // Byte sitting in the addressed lane of a bus word.
  function automatic logic [7:0] lane_extract(input logic [MAXDW-1:0] data,
                                              input logic [MAXLANEW-1:0] lane);
    return data[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ldst_agu.sv
// Combinational address generator: base +/- zero-extended immediate,
// pre/post-index selection and word-misalignment detection. Kept free of
// any load/store state so the branch/PC path can reuse it.
module ldst_agu #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int OFFW = 12,
  parameter int LW   = 2
) (
  input  logic [DW-1:0]   rn_val,
  input  logic [OFFW-1:0] offset,
  input  logic            p,
  input  logic            u,
  output logic [AW-1:0]   ea,
  output logic [AW-1:0]   addr,
  output logic            misaligned
);

  // Arithmetic is done wide enough for every operand, then wrapped to AW.
  localparam int SW0 = (AW > DW) ? AW : DW;
  localparam int SW  = (SW0 > OFFW) ? SW0 : OFFW;

  logic [SW-1:0] base_ext;
  logic [SW-1:0] off_ext;
  logic [SW-1:0] sum;

  // Effective address, access address and low-bit alignment test.
  always_comb begin
    base_ext   = SW'(rn_val);
    off_ext    = SW'(offset);
    sum        = u ? (base_ext + off_ext) : (base_ext - off_ext);
    ea         = AW'(sum);
    addr       = p ? ea : AW'(base_ext);
    misaligned = |addr[LW-1:0];
  end

endmodule

// File: rtl/ldst_exec_stage.sv
// Execute/memory stage for LDR/STR: latches a decoded instruction, computes
// its address, runs one req/ack memory transaction with a timeout, then
// retires it with up to two register-file writebacks in a single WB cycle.
module ldst_exec_stage
  import ldst_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int RW       = 4,
  parameter int OFFW     = 12,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cond_pass,
  input  logic              is_ldr,
  input  logic              is_str,
  input  logic              p,
  input  logic              u,
  input  logic              bsel,
  input  logic              w,
  input  logic [RW-1:0]     rn,
  input  logic [RW-1:0]     rd,
  input  logic [DW-1:0]     rn_val,
  input  logic [DW-1:0]     rd_val,
  input  logic [OFFW-1:0]   offset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,
  output logic              wb_rd_en,
  output logic [RW-1:0]     wb_rd_addr,
  output logic [DW-1:0]     wb_rd_data,
  output logic              wb_rn_en,
  output logic [RW-1:0]     wb_rn_addr,
  output logic [DW-1:0]     wb_rn_data,
  output logic              done,
  output logic              fault
);

  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  ldst_state_t     state_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic            ldr_reg;
  logic            bsel_reg;
  logic            rnwb_reg;
  logic [RW-1:0]   rn_reg;
  logic [RW-1:0]   rd_reg;
  logic [AW-1:0]   ea_reg;

  logic [AW-1:0]   agu_ea;
  logic [AW-1:0]   agu_addr;
  logic            agu_mis;

  logic            do_ldr;
  logic            do_str;
  logic            do_access;
  logic [DW-1:0]   wdata_next;
  logic [NB-1:0]   be_next;
  logic [DW-1:0]   load_data;
  logic [CW-1:0]   wait_inc;
  logic            timeout;

  ldst_agu #(
    .DW   (DW),
    .AW   (AW),
    .OFFW (OFFW),
    .LW   (LW)
  ) u_agu (
    .rn_val     (rn_val),
    .offset     (offset),
    .p          (p),
    .u          (u),
    .ea         (agu_ea),
    .addr       (agu_addr),
    .misaligned (agu_mis)
  );

  // Decode of the incoming instruction and the memory-side data paths.
  always_comb begin
    do_ldr    = cond_pass && is_ldr;
    do_str    = cond_pass && is_str && !is_ldr;
    do_access = do_ldr || do_str;

    if (bsel) begin
      wdata_next = DW'(byte_replicate(rd_val[7:0]));
      be_next    = NB'(be_decode(MAXLANEW'(agu_addr[LW-1:0])));
    end else begin
      wdata_next = rd_val;
      be_next    = '1;
    end

    // Byte loads come from the lane selected by the held request address.
    if (bsel_reg)
      load_data = DW'(lane_extract(MAXDW'(mem_rdata), MAXLANEW'(mem_addr[LW-1:0])));
    else
      load_data = mem_rdata;

    wait_inc = wait_cnt_reg + CW'(1);
    timeout  = (MAX_WAIT != 0) && (wait_inc == CW'(MAX_WAIT));
  end

  // Stage FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      ldr_reg      <= 1'b0;
      bsel_reg     <= 1'b0;
      rnwb_reg     <= 1'b0;
      rn_reg       <= '0;
      rd_reg       <= '0;
      ea_reg       <= '0;
      in_ready     <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      wb_rd_en     <= 1'b0;
      wb_rd_addr   <= '0;
      wb_rd_data   <= '0;
      wb_rn_en     <= 1'b0;
      wb_rn_addr   <= '0;
      wb_rn_data   <= '0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      // Pulsed outputs default low; the transition into WB/FAULT raises them.
      done     <= 1'b0;
      fault    <= 1'b0;
      wb_rd_en <= 1'b0;
      wb_rn_en <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            ldr_reg  <= do_ldr;
            bsel_reg <= bsel;
            rnwb_reg <= w || !p;
            rn_reg   <= rn;
            rd_reg   <= rd;
            ea_reg   <= agu_ea;
            if (!do_access) begin
              // Condition failed or not a memory op: retire with no writes.
              state_reg <= ST_WB;
              done      <= 1'b1;
            end else if (!bsel && agu_mis) begin
              state_reg <= ST_FAULT;
              fault     <= 1'b1;
            end else begin
              state_reg    <= ST_REQ;
              wait_cnt_reg <= '0;
              mem_req      <= 1'b1;
              mem_we       <= do_str;
              mem_addr     <= agu_addr;
              mem_wdata    <= wdata_next;
              mem_be       <= be_next;
            end
          end
        end

        ST_REQ: begin
          if (mem_ack) begin
            state_reg  <= ST_WB;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            done       <= 1'b1;
            wb_rd_en   <= ldr_reg;
            wb_rd_addr <= rd_reg;
            wb_rd_data <= load_data;
            // A load into the base register takes priority over base update.
            wb_rn_en   <= rnwb_reg && !(ldr_reg && (rn_reg == rd_reg));
            wb_rn_addr <= rn_reg;
            wb_rn_data <= DW'(ea_reg);
          end else if (timeout) begin
            state_reg <= ST_FAULT;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            fault     <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_inc;
          end
        end

        ST_WB: begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b1;
        end

        ST_FAULT: begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b1;
        end

        default: begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_exec_stage.sv
// Bench for ldst_exec_stage: directed vector table, reset corner cases and
// randomized instructions checked against an arithmetic reference model.
module tb_ldst_exec_stage;

  localparam int DW = 32, AW = 32, RW = 4, OFFW = 12, MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 0, in_ready;
  logic cond_pass = 0, is_ldr = 0, is_str = 0, p = 0, u = 0, bsel = 0, w = 0;
  logic [RW-1:0] rn = '0, rd = '0;
  logic [DW-1:0] rn_val = '0, rd_val = '0;
  logic [OFFW-1:0] offset = '0;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic mem_ack = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic wb_rd_en, wb_rn_en, done, fault;
  logic [RW-1:0] wb_rd_addr, wb_rn_addr;
  logic [DW-1:0] wb_rd_data, wb_rn_data;

  always #5 clk = ~clk;

  ldst_exec_stage #(.DW(DW), .AW(AW), .RW(RW), .OFFW(OFFW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond_pass(cond_pass), .is_ldr(is_ldr), .is_str(is_str), .p(p), .u(u),
    .bsel(bsel), .w(w), .rn(rn), .rd(rd), .rn_val(rn_val), .rd_val(rd_val),
    .offset(offset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_rn_en(wb_rn_en), .wb_rn_addr(wb_rn_addr), .wb_rn_data(wb_rn_data),
    .done(done), .fault(fault)
  );

  typedef struct {
    logic        cond, ldr, str, p, u, bsel, w;
    logic [3:0]  rn, rd;
    logic [31:0] rn_val, rd_val;
    logic [11:0] offset;
    int          ack_delay;   // REQ cycle index that sees ack; -1 = never
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    int          nreq;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ndone, nfault, nrd;
    logic [31:0] rd_data;
    int          nrn;
    logic [31:0] rn_data;
    int          ready;       // cycles from accept until in_ready is seen high
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Reference behaviour derived directly from the instruction semantics.
  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [31:0] ea, a;
    bit exec, mis, tmo;
    int lane;
    e = '{default: 0};
    ea   = o.u ? (o.rn_val + 32'(o.offset)) : (o.rn_val - 32'(o.offset));
    a    = o.p ? ea : o.rn_val;
    lane = int'(a % 4);
    exec = o.cond && (o.ldr || o.str);
    mis  = exec && !o.bsel && (lane != 0);
    tmo  = exec && !mis && (o.ack_delay < 0 || o.ack_delay >= MAX_WAIT);
    if (!exec) begin
      e.ndone = 1; e.ready = 2;
    end else if (mis) begin
      e.nfault = 1; e.ready = 2;
    end else begin
      e.addr  = a;
      e.we    = !o.ldr;
      e.be    = o.bsel ? 4'(1 << lane) : 4'hF;
      e.wdata = o.bsel ? {4{o.rd_val[7:0]}} : o.rd_val;
      if (tmo) begin
        e.nreq = MAX_WAIT; e.nfault = 1; e.ready = MAX_WAIT + 2;
      end else begin
        e.nreq = o.ack_delay + 1; e.ndone = 1; e.ready = o.ack_delay + 3;
        if (o.ldr) begin
          e.nrd = 1;
          e.rd_data = o.bsel ? ((o.rdata >> (8 * lane)) & 32'hFF) : o.rdata;
        end
        if ((o.w || !o.p) && !(o.ldr && o.rn == o.rd)) begin
          e.nrn = 1; e.rn_data = ea;
        end
      end
    end
    return e;
  endfunction

  // Issue one instruction, play the memory side, and compare everything seen.
  task automatic run_op(input string tag, input op_t o, input exp_t e);
    int wait_c, nreq, ndone, nfault, nrd, nrn, ready_at;
    logic [31:0] addr0, wdata0, rd_data, rn_data;
    logic [3:0] be0, rd_a, rn_a;
    logic we0, stable;
    wait_c = 0;
    @(negedge clk);
    while (!in_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check({tag, ".idle_ready"}, in_ready, 1'b1);
    cond_pass = o.cond; is_ldr = o.ldr; is_str = o.str; p = o.p; u = o.u;
    bsel = o.bsel; w = o.w; rn = o.rn; rd = o.rd; rn_val = o.rn_val;
    rd_val = o.rd_val; offset = o.offset; in_valid = 1'b1;
    nreq = 0; ndone = 0; nfault = 0; nrd = 0; nrn = 0; ready_at = -1;
    addr0 = '0; wdata0 = '0; be0 = '0; we0 = 0; stable = 1;
    rd_data = '0; rn_data = '0; rd_a = '0; rn_a = '0;
    for (int cyc = 1; cyc <= 40 && ready_at < 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      if (done) ndone++;
      if (fault) nfault++;
      if (wb_rd_en) begin nrd++; rd_data = wb_rd_data; rd_a = wb_rd_addr; end
      if (wb_rn_en) begin nrn++; rn_data = wb_rn_data; rn_a = wb_rn_addr; end
      if (mem_req) begin
        if (nreq == 0) begin
          addr0 = mem_addr; wdata0 = mem_wdata; be0 = mem_be; we0 = mem_we;
        end else if (mem_addr !== addr0 || mem_wdata !== wdata0 ||
                     mem_be !== be0 || mem_we !== we0) begin
          stable = 0;
        end
        if (o.ack_delay == nreq) begin
          mem_ack = 1'b1; mem_rdata = o.rdata;
        end else begin
          mem_rdata = $urandom;
        end
        nreq++;
      end
      if (in_ready) ready_at = cyc;
    end
    mem_ack = 1'b0;
    check({tag, ".nreq"}, nreq, e.nreq);
    if (e.nreq > 0) begin
      check({tag, ".addr"}, addr0, e.addr);
      check({tag, ".we"}, we0, e.we);
      check({tag, ".stable"}, stable, 1'b1);
      if (e.we) begin
        check({tag, ".be"}, be0, e.be);
        check({tag, ".wdata"}, wdata0, e.wdata);
      end
    end
    check({tag, ".done"}, ndone, e.ndone);
    check({tag, ".fault"}, nfault, e.nfault);
    check({tag, ".wb_rd_en"}, nrd, e.nrd);
    if (e.nrd > 0) begin
      check({tag, ".wb_rd_data"}, rd_data, e.rd_data);
      check({tag, ".wb_rd_addr"}, rd_a, o.rd);
    end
    check({tag, ".wb_rn_en"}, nrn, e.nrn);
    if (e.nrn > 0) begin
      check({tag, ".wb_rn_data"}, rn_data, e.rn_data);
      check({tag, ".wb_rn_addr"}, rn_a, o.rn);
    end
    check({tag, ".ready_lat"}, ready_at, e.ready);
    $display("%s: cond=%0d ldr=%0d str=%0d p=%0d u=%0d b=%0d w=%0d rn_val=%08h off=%03h ack=%0d -> nreq=%0d done=%0d fault=%0d rd=%0d rn=%0d ready=%0d",
             tag, o.cond, o.ldr, o.str, o.p, o.u, o.bsel, o.w, o.rn_val, o.offset,
             o.ack_delay, nreq, ndone, nfault, nrd, nrn, ready_at);
  endtask

  vec_t vecs[11];
  op_t  rop;
  int   nevents;

  initial begin
    vecs[0]  = '{'{1,0,1,1,1,0,1,4'd1,4'd2,32'h100,32'hDEADBEEF,12'd8,2,32'h0},
                 '{3,32'h108,1,4'hF,32'hDEADBEEF,1,0,0,32'h0,1,32'h108,5}};
    vecs[1]  = '{'{1,1,0,0,0,1,0,4'd4,4'd5,32'h203,32'h0,12'd4,0,32'hAABBCCDD},
                 '{1,32'h203,0,4'h8,32'h0,1,0,1,32'hAA,1,32'h1FF,3}};
    vecs[2]  = '{'{1,1,0,1,1,0,0,4'd6,4'd7,32'h40,32'h0,12'd0,-1,32'h0},
                 '{16,32'h40,0,4'hF,32'h0,0,1,0,32'h0,0,32'h0,18}};
    vecs[3]  = '{'{1,1,0,1,1,0,0,4'd1,4'd2,32'h100,32'h0,12'd2,0,32'h0},
                 '{0,32'h0,0,4'h0,32'h0,0,1,0,32'h0,0,32'h0,2}};
    vecs[4]  = '{'{0,0,1,1,1,0,1,4'd1,4'd2,32'h100,32'h1234,12'd4,0,32'h0},
                 '{0,32'h0,0,4'h0,32'h0,1,0,0,32'h0,0,32'h0,2}};
    vecs[5]  = '{'{1,1,0,1,1,0,1,4'd3,4'd3,32'h300,32'h0,12'h10,1,32'h12345678},
                 '{2,32'h310,0,4'hF,32'h0,1,0,1,32'h12345678,0,32'h0,4}};
    vecs[6]  = '{'{1,0,1,1,0,0,0,4'd8,4'd9,32'h0,32'hCAFEF00D,12'd4,0,32'h0},
                 '{1,32'hFFFFFFFC,1,4'hF,32'hCAFEF00D,1,0,0,32'h0,0,32'h0,3}};
    vecs[7]  = '{'{1,1,0,0,1,0,0,4'd10,4'd11,32'h500,32'h0,12'h20,15,32'h0BADCAFE},
                 '{16,32'h500,0,4'hF,32'h0,1,0,1,32'h0BADCAFE,1,32'h520,18}};
    vecs[8]  = '{'{1,0,0,1,1,0,1,4'd1,4'd2,32'h100,32'h0,12'd4,0,32'h0},
                 '{0,32'h0,0,4'h0,32'h0,1,0,0,32'h0,0,32'h0,2}};
    vecs[9]  = '{'{1,0,1,1,1,1,1,4'd12,4'd13,32'h1000,32'h77665544,12'd1,3,32'h0},
                 '{4,32'h1001,1,4'h2,32'h44444444,1,0,0,32'h0,1,32'h1001,6}};
    vecs[10] = '{'{1,1,0,1,1,1,0,4'd14,4'd15,32'h2000,32'h0,12'h10,0,32'h11223344},
                 '{1,32'h2010,0,4'h1,32'h0,1,0,1,32'h44,0,32'h0,3}};

    // Reset state while held and right after release.
    repeat (2) @(negedge clk);
    check("rst.mem_req", mem_req, 1'b0);
    check("rst.mem_we", mem_we, 1'b0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_be", mem_be, 4'h0);
    check("rst.wb_rd_en", wb_rd_en, 1'b0);
    check("rst.wb_rn_en", wb_rn_en, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.fault", fault, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", in_ready, 1'b1);
    $display("reset: in_ready=%0d mem_req=%0d done=%0d fault=%0d", in_ready, mem_req, done, fault);

    // Directed vector table.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp);

    // Reset asserted in the middle of a memory request.
    @(negedge clk);
    cond_pass = 1; is_ldr = 1; is_str = 0; p = 1; u = 1; bsel = 0; w = 1;
    rn = 4'd2; rd = 4'd3; rn_val = 32'h400; offset = 12'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_rst.req_before", mem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst.mem_req", mem_req, 1'b0);
    check("mid_rst.done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nevents = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || fault || wb_rd_en || wb_rn_en || mem_req) nevents++;
    end
    check("mid_rst.quiet_after", nevents, 0);
    $display("mid_rst: mem_req dropped, events after release=%0d", nevents);
    run_op("post_rst", vecs[0].op, vecs[0].exp);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop.cond   = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 6))
        0:       begin rop.ldr = 0; rop.str = 0; end
        1, 2, 3: begin rop.ldr = 1; rop.str = 0; end
        default: begin rop.ldr = 0; rop.str = 1; end
      endcase
      rop.p      = $urandom_range(0, 1);
      rop.u      = $urandom_range(0, 1);
      rop.bsel   = $urandom_range(0, 1);
      rop.w      = $urandom_range(0, 1);
      rop.rn     = 4'($urandom_range(0, 15));
      rop.rd     = ($urandom_range(0, 4) == 0) ? rop.rn : 4'($urandom_range(0, 15));
      rop.rn_val = $urandom;
      if ($urandom_range(0, 4) != 0) rop.rn_val[1:0] = 2'b00;
      rop.offset = 12'($urandom);
      if ($urandom_range(0, 4) != 0) rop.offset[1:0] = 2'b00;
      rop.rd_val = $urandom;
      rop.rdata  = $urandom;
      case ($urandom_range(0, 9))
        0:       rop.ack_delay = -1;
        1:       rop.ack_delay = MAX_WAIT - 1;
        2:       rop.ack_delay = MAX_WAIT;
        default: rop.ack_delay = $urandom_range(0, 4);
      endcase
      run_op($sformatf("rnd%0d", i), rop, model(rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
